led_scan_ctrl: RTL and testbench

Scan sequencer for a HUB75-style dual-scan RGB LED panel. Reads pixel words from a framebuffer port with one-cycle read latency and drives the panel pins: six serial colour bits, row address RA..RD, shift clock, latch, and an active-low output enable. Brightness uses binary-code modulation with one bit-plane per colour bit. It sits between the framebuffer RAM and the panel connector and owns all panel timing.

---
 rtl/led_scan_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_led_scan_ctrl.sv | 469 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_scan_ctrl.sv
// led_scan_ctrl: HUB75-style dual-scan RGB LED panel scan sequencer.
// Fetches pixel words from a one-cycle-latency framebuffer port, shifts one
// bit-plane per row pair into the panel, latches it, then lights it for a
// binary-weighted time (OE_BASE << plane cycles).
//
// Every output is a register loaded from the *next* FSM state, so the panel
// pins always show the state the FSM is in during that cycle. The first SHIFT
// cycle carries no clock pulse: it covers the framebuffer read latency, while
// the word for column COLS-1 is in flight.
module led_scan_ctrl #(
  parameter int COLS     = 32,
  parameter int ROW_BITS = 4,
  parameter int BPC      = 4,
  parameter int OE_BASE  = 8
) (
  input  logic                             CLK_I,
  input  logic                             RST_I,
  input  logic                             EN_I,
  output logic [ROW_BITS+$clog2(COLS)-1:0] FB_ADDR_O,
  input  logic [6*BPC-1:0]                 FB_DATA_I,
  output logic                             R0,
  output logic                             G0,
  output logic                             B0,
  output logic                             R1,
  output logic                             G1,
  output logic                             B1,
  output logic                             RA,
  output logic                             RB,
  output logic                             RC,
  output logic                             RD,
  output logic                             CLK_O,
  output logic                             LATCH,
  output logic                             OE,
  output logic                             FRAME_O
);

  localparam int CBITS    = $clog2(COLS);
  localparam int ROWS     = 1 << ROW_BITS;
  localparam int DISP_MAX = OE_BASE << (BPC - 1);
  localparam int SPAN     = (DISP_MAX > 2 * COLS) ? DISP_MAX : 2 * COLS;
  localparam int CNT_W    = $clog2(SPAN + 1);
  localparam int PW       = (BPC > 1) ? $clog2(BPC) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREFETCH,
    S_SHIFT,
    S_BLANK,
    S_LATCH,
    S_DISPLAY
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [CNT_W-1:0]     r_cnt;
  logic [CNT_W-1:0]     w_cnt_nxt;
  logic [ROW_BITS-1:0]  r_row;
  logic [ROW_BITS-1:0]  w_row_nxt;
  logic [PW-1:0]        r_plane;
  logic [PW-1:0]        w_plane_nxt;
  logic [CNT_W-1:0]     w_disp_last;
  logic                 w_frame_end;
  logic [CNT_W-1:0]     w_step;
  logic [CBITS-1:0]     w_col;
  logic [5:0]           w_bits;

  // FSM state, sequencing counter, row and bit-plane registers
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_row   <= '0;
      r_plane <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_row   <= w_row_nxt;
      r_plane <= w_plane_nxt;
    end
  end

  // Next-state logic: shift, blank, latch, display, then advance plane/row
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_row_nxt   = r_row;
    w_plane_nxt = r_plane;
    w_disp_last = (CNT_W'(OE_BASE) << r_plane) - CNT_W'(1);
    w_frame_end = (r_row == ROW_BITS'(ROWS - 1)) && (r_plane == PW'(BPC - 1));
    case (r_state)
      S_IDLE: begin
        if (EN_I) begin
          w_state_nxt = S_PREFETCH;
          w_row_nxt   = '0;
          w_plane_nxt = '0;
        end
      end
      S_PREFETCH: begin
        w_state_nxt = S_SHIFT;
        w_cnt_nxt   = '0;
      end
      S_SHIFT: begin
        // Count 0 is the read-latency slot; counts 1..2*COLS are half-cycles
        if (r_cnt == CNT_W'(2 * COLS)) begin
          w_state_nxt = S_BLANK;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_BLANK: begin
        w_state_nxt = S_LATCH;
      end
      S_LATCH: begin
        w_state_nxt = S_DISPLAY;
        w_cnt_nxt   = '0;
      end
      S_DISPLAY: begin
        if (r_cnt == w_disp_last) begin
          if (w_frame_end) begin
            // End of frame is the only place besides IDLE where EN_I is looked at
            w_row_nxt   = '0;
            w_plane_nxt = '0;
            w_state_nxt = EN_I ? S_PREFETCH : S_IDLE;
          end else begin
            w_state_nxt = S_PREFETCH;
            if (r_plane == PW'(BPC - 1)) begin
              w_plane_nxt = '0;
              w_row_nxt   = r_row + ROW_BITS'(1);
            end else begin
              w_plane_nxt = r_plane + PW'(1);
            end
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Column address for the next cycle and bit-plane select of the incoming word
  always_comb begin
    w_step = (w_cnt_nxt + CNT_W'(1)) >> 1;
    if (w_step >= CNT_W'(COLS - 1)) begin
      w_col = '0;
    end else begin
      w_col = CBITS'(CNT_W'(COLS - 1) - w_step);
    end
    w_bits = '0;
    for (int k = 0; k < 6; k++) begin
      for (int b = 0; b < BPC; b++) begin
        if (PW'(b) == r_plane) begin
          w_bits[k] = FB_DATA_I[k*BPC+b];
        end
      end
    end
  end

  // Registered panel pins and framebuffer address, decoded from the next state
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      FB_ADDR_O          <= '0;
      {B1, G1, R1}       <= 3'b000;
      {B0, G0, R0}       <= 3'b000;
      {RD, RC, RB, RA}   <= 4'b0000;
      CLK_O              <= 1'b0;
      LATCH              <= 1'b0;
      OE                 <= 1'b1;
      FRAME_O            <= 1'b0;
    end else begin
      if (w_state_nxt == S_PREFETCH) begin
        FB_ADDR_O <= {w_row_nxt, CBITS'(COLS - 1)};
      end else if (w_state_nxt == S_SHIFT) begin
        FB_ADDR_O <= {w_row_nxt, w_col};
      end
      // New column data lands on the low half-cycle, one cycle after its read
      if ((w_state_nxt == S_SHIFT) && w_cnt_nxt[0]) begin
        {B1, G1, R1, B0, G0, R0} <= w_bits;
      end
      CLK_O <= (w_state_nxt == S_SHIFT) && !w_cnt_nxt[0] && (w_cnt_nxt != '0);
      LATCH <= (w_state_nxt == S_LATCH);
      if (w_state_nxt == S_LATCH) begin
        {RD, RC, RB, RA} <= w_row_nxt;
      end
      OE      <= (w_state_nxt != S_DISPLAY);
      FRAME_O <= (w_state_nxt == S_DISPLAY) && (w_cnt_nxt == w_disp_last) && w_frame_end;
    end
  end

endmodule

// File: tb/tb_led_scan_ctrl.sv
// tb_led_scan_ctrl: self-checking bench for led_scan_ctrl with default parameters.
// A framebuffer model answers reads one cycle late; expected column bits are
// queued per plane and popped at each panel shift-clock rising edge.
module tb_led_scan_ctrl;

  localparam int COLS    = 32;
  localparam int BPC     = 4;
  localparam int OE_BASE = 8;
  localparam int FRAME   = 6272;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [23:0] fb_data;
  logic [8:0]  fb_addr;
  logic        r0, g0, b0, r1, g1, b1;
  logic        ra, rb, rc, rd;
  logic        clk_o, latch, oe, frame;
  logic [5:0]  pins;
  logic [3:0]  row_pins;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          fb_mode = 0;
  logic [5:0]  sb[$];

  assign pins     = {b1, g1, r1, b0, g0, r0};
  assign row_pins = {rd, rc, rb, ra};

  always #5 clk = ~clk;

  led_scan_ctrl #(
    .COLS    (COLS),
    .ROW_BITS(4),
    .BPC     (BPC),
    .OE_BASE (OE_BASE)
  ) dut (
    .CLK_I    (clk),
    .RST_I    (rst),
    .EN_I     (en),
    .FB_ADDR_O(fb_addr),
    .FB_DATA_I(fb_data),
    .R0       (r0),
    .G0       (g0),
    .B0       (b0),
    .R1       (r1),
    .G1       (g1),
    .B1       (b1),
    .RA       (ra),
    .RB       (rb),
    .RC       (rc),
    .RD       (rd),
    .CLK_O    (clk_o),
    .LATCH    (latch),
    .OE       (oe),
    .FRAME_O  (frame)
  );

  function automatic logic [23:0] fb_word(input logic [8:0] a, input int mode);
    if (mode == 0) return 24'hFFFFFF;
    return {~a[5:0], a, a};
  endfunction

  function automatic logic [5:0] exp_pins(input logic [3:0] row, input int col, input int p,
                                          input int mode);
    logic [23:0] w;
    logic [5:0]  e;
    logic [4:0]  c;
    c = col[4:0];
    w = fb_word({row, c}, mode);
    for (int k = 0; k < 6; k++) e[k] = w[k*BPC+p];
    return e;
  endfunction

  function automatic int plane_len(input int p);
    return 2 * COLS + 4 + (OE_BASE << p);
  endfunction

  // Framebuffer: data for the address seen in one cycle appears in the next
  initial begin
    logic [8:0] a_q;
    fb_data = '0;
    forever begin
      @(negedge clk);
      a_q = fb_addr;
      @(posedge clk);
      #1;
      fb_data = fb_word(a_q, fb_mode);
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    en  = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Waits (bounded) for the first PREFETCH address of row 0
  task automatic wait_start(output int waitc);
    waitc = 0;
    do begin
      @(negedge clk);
      waitc++;
    end while (fb_addr !== 9'h01F && waitc < 10);
  endtask

  task automatic test_reset();
    int waitc;
    int idle_bad;
    rst = 1'b1;
    en  = 1'b0;
    @(negedge clk);
    n_tests++;
    if (oe !== 1'b1) begin
      $display("FAIL reset_oe got %b want 1", oe);
      n_fail++;
    end
    n_tests++;
    if ({fb_addr, pins, row_pins, clk_o, latch, frame} !== '0) begin
      $display("FAIL reset_zero got addr=%h pins=%h row=%h clk=%b lat=%b frm=%b want all 0",
               fb_addr, pins, row_pins, clk_o, latch, frame);
      n_fail++;
    end
    rst = 1'b0;
    idle_bad = 0;
    repeat (30) begin
      @(negedge clk);
      if (oe !== 1'b1 || clk_o !== 1'b0 || latch !== 1'b0 || fb_addr !== 9'h000) idle_bad++;
    end
    n_tests++;
    if (idle_bad != 0) begin
      $display("FAIL idle_no_en got %0d active cycles want 0", idle_bad);
      n_fail++;
    end
    // Reset in the middle of a DISPLAY period
    en = 1'b1;
    waitc = 0;
    do begin
      @(negedge clk);
      waitc++;
    end while (oe !== 1'b0 && waitc < 200);
    n_tests++;
    if (waitc >= 200) begin
      $display("FAIL reach_display got timeout want OE low within 200 cycles");
      n_fail++;
    end
    repeat (3) @(negedge clk);
    #2;
    rst = 1'b1;
    en  = 1'b0;
    #1;
    n_tests++;
    if (oe !== 1'b1 || {fb_addr, pins, row_pins, clk_o, latch, frame} !== '0) begin
      $display("FAIL async_reset got oe=%b addr=%h pins=%h row=%h clk=%b lat=%b want oe=1 rest 0",
               oe, fb_addr, pins, row_pins, clk_o, latch);
      n_fail++;
    end
    @(negedge clk);
    rst = 1'b0;
    idle_bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (oe !== 1'b1 || clk_o !== 1'b0 || latch !== 1'b0 || fb_addr !== 9'h000) idle_bad++;
    end
    n_tests++;
    if (idle_bad != 0) begin
      $display("FAIL idle_after_reset got %0d active cycles want 0", idle_bad);
      n_fail++;
    end
  endtask

  task automatic test_single_plane();
    int   waitc, edges, clk_bad, pin_bad, latch_cnt, latch_bad, oe_low, oe_bad, unsafe;
    logic prev_clk;
    logic exp_clk, exp_latch, exp_oe;
    logic [8:0] last_addr;
    do_reset();
    fb_mode = 0;
    en = 1'b1;
    wait_start(waitc);
    n_tests++;
    if (waitc != 1) begin
      $display("FAIL start_latency got %0d cycles want 1", waitc);
      n_fail++;
    end
    edges = 0; clk_bad = 0; pin_bad = 0; latch_cnt = 0; latch_bad = 0;
    oe_low = 0; oe_bad = 0; unsafe = 0; prev_clk = 1'b0; last_addr = '0;
    for (int i = 0; i < 76; i++) begin
      if (i != 0) @(negedge clk);
      exp_clk   = (i >= 3) && (i <= 65) && (i % 2 == 1);
      exp_latch = (i == 67);
      exp_oe    = !((i >= 68) && (i < 76));
      if (clk_o !== exp_clk) clk_bad++;
      if (clk_o && !prev_clk) edges++;
      if (clk_o && pins !== 6'h3F) pin_bad++;
      if (latch) latch_cnt++;
      if (latch !== exp_latch) latch_bad++;
      if (!oe) oe_low++;
      if (oe !== exp_oe) oe_bad++;
      if (!oe && (clk_o || latch)) unsafe++;
      prev_clk  = clk_o;
      last_addr = fb_addr;
    end
    n_tests++;
    if (edges != 32) begin
      $display("FAIL clk_edges got %0d want 32", edges);
      n_fail++;
    end
    n_tests++;
    if (clk_bad != 0) begin
      $display("FAIL clk_timing got %0d wrong cycles want 0", clk_bad);
      n_fail++;
    end
    n_tests++;
    if (pin_bad != 0) begin
      $display("FAIL colour_ones got %0d wrong columns want 0", pin_bad);
      n_fail++;
    end
    n_tests++;
    if (latch_cnt != 1 || latch_bad != 0) begin
      $display("FAIL latch_pulse got %0d high (%0d misplaced) want 1 at offset 67",
               latch_cnt, latch_bad);
      n_fail++;
    end
    n_tests++;
    if (oe_low != 8 || oe_bad != 0) begin
      $display("FAIL oe_window got %0d low (%0d misplaced) want 8 at 68..75", oe_low, oe_bad);
      n_fail++;
    end
    n_tests++;
    if (unsafe != 0) begin
      $display("FAIL oe_safety got %0d unsafe cycles want 0", unsafe);
      n_fail++;
    end
    @(negedge clk);
    n_tests++;
    if (last_addr !== 9'h000 || fb_addr !== 9'h01F) begin
      $display("FAIL next_prefetch got %h->%h want 000->01f at offset 76", last_addr, fb_addr);
      n_fail++;
    end
  endtask

  task automatic test_addr_bits();
    int   waitc, addr_bad, sb_empty;
    logic prev_clk;
    logic [5:0] low_pins, e;
    logic [8:0] exp_a;
    logic [4:0] c;
    do_reset();
    fb_mode = 1;
    en = 1'b1;
    wait_start(waitc);
    n_tests++;
    if (waitc != 1) begin
      $display("FAIL addr_start got %0d cycles want 1", waitc);
      n_fail++;
    end
    sb.delete();
    addr_bad = 0; sb_empty = 0; prev_clk = 1'b0; low_pins = '0;
    for (int p = 0; p < BPC; p++) begin
      for (int col = COLS - 1; col >= 0; col--) sb.push_back(exp_pins(4'd0, col, p, 1));
      for (int i = 0; i < plane_len(p); i++) begin
        if (!(p == 0 && i == 0)) @(negedge clk);
        if (i % 2 == 0 && i / 2 < COLS) begin
          c = 5'(COLS - 1 - i / 2);
          exp_a = {4'd0, c};
          if (fb_addr !== exp_a) begin
            if (addr_bad == 0)
              $display("FAIL fb_addr p=%0d i=%0d got %h want %h", p, i, fb_addr, exp_a);
            addr_bad++;
          end
        end
        if (!clk_o) low_pins = pins;
        if (clk_o && !prev_clk) begin
          if (sb.size() == 0) begin
            sb_empty++;
          end else begin
            e = sb.pop_front();
            n_tests++;
            if (pins !== e || low_pins !== e) begin
              $display("FAIL col_bits p=%0d i=%0d got low=%h high=%h want %h",
                       p, i, low_pins, pins, e);
              n_fail++;
            end
          end
        end
        prev_clk = clk_o;
      end
      n_tests++;
      if (sb.size() != 0 || sb_empty != 0) begin
        $display("FAIL sb_drain p=%0d got %0d left, %0d extra edges want 0/0",
                 p, sb.size(), sb_empty);
        n_fail++;
        sb.delete();
        sb_empty = 0;
      end
    end
    n_tests++;
    if (addr_bad != 0) begin
      $display("FAIL addr_sequence got %0d wrong addresses want 0", addr_bad);
      n_fail++;
    end
    @(negedge clk);
    n_tests++;
    if (fb_addr !== 9'h03F) begin
      $display("FAIL row_advance got %h want 03f", fb_addr);
      n_fail++;
    end
  endtask

  task automatic test_bcm();
    int waitc, oe_low, row_bad;
    int weights[4] = '{8, 16, 32, 64};
    do_reset();
    fb_mode = 0;
    en = 1'b1;
    wait_start(waitc);
    n_tests++;
    if (waitc != 1) begin
      $display("FAIL bcm_start got %0d cycles want 1", waitc);
      n_fail++;
    end
    row_bad = 0;
    for (int p = 0; p < BPC; p++) begin
      oe_low = 0;
      for (int i = 0; i < plane_len(p); i++) begin
        if (!(p == 0 && i == 0)) @(negedge clk);
        if (!oe) begin
          oe_low++;
          if (row_pins !== 4'd0) row_bad++;
        end
      end
      n_tests++;
      if (oe_low != weights[p]) begin
        $display("FAIL bcm_weight p=%0d got %0d want %0d", p, oe_low, weights[p]);
        n_fail++;
      end
    end
    n_tests++;
    if (row_bad != 0) begin
      $display("FAIL bcm_row got %0d cycles with RA..RD!=0 want 0", row_bad);
      n_fail++;
    end
  endtask

  task automatic test_frame();
    int waitc, row_bad, frame_hi;
    int frame_offs[$];
    int latch_rows[$];
    do_reset();
    fb_mode = 0;
    en = 1'b1;
    wait_start(waitc);
    n_tests++;
    if (waitc != 1) begin
      $display("FAIL frame_start got %0d cycles want 1", waitc);
      n_fail++;
    end
    frame_hi = 0;
    for (int i = 0; i < 2 * FRAME + 80; i++) begin
      if (i != 0) @(negedge clk);
      if (frame) begin
        frame_hi++;
        frame_offs.push_back(i);
      end
      if (latch) latch_rows.push_back(int'(row_pins));
    end
    n_tests++;
    if (frame_hi != 2 || frame_offs.size() != 2) begin
      $display("FAIL frame_count got %0d want 2", frame_hi);
      n_fail++;
    end else begin
      n_tests++;
      if (frame_offs[0] != FRAME - 1 || frame_offs[1] != 2 * FRAME - 1) begin
        $display("FAIL frame_offset got %0d,%0d want %0d,%0d",
                 frame_offs[0], frame_offs[1], FRAME - 1, 2 * FRAME - 1);
        n_fail++;
      end
    end
    n_tests++;
    if (latch_rows.size() != 129) begin
      $display("FAIL latch_count got %0d want 129", latch_rows.size());
      n_fail++;
    end else begin
      row_bad = 0;
      for (int j = 0; j < 129; j++) if (latch_rows[j] != (j / 4) % 16) row_bad++;
      n_tests++;
      if (row_bad != 0) begin
        $display("FAIL row_sequence got %0d wrong latched rows want 0", row_bad);
        n_fail++;
      end
      n_tests++;
      if (latch_rows[63] != 15 || latch_rows[128] != 0) begin
        $display("FAIL row_wrap got %0d then %0d want 15 then 0",
                 latch_rows[63], latch_rows[128]);
        n_fail++;
      end
    end
  endtask

  task automatic test_en_drop();
    int   waitc, frame_at, frame_cnt, latch_cnt, last_row, post_active;
    logic dropped;
    do_reset();
    fb_mode = 0;
    en = 1'b1;
    wait_start(waitc);
    n_tests++;
    if (waitc != 1) begin
      $display("FAIL drop_start got %0d cycles want 1", waitc);
      n_fail++;
    end
    dropped = 1'b0; frame_at = -1; frame_cnt = 0; latch_cnt = 0; last_row = -1;
    post_active = 0;
    for (int i = 0; i < FRAME + 300; i++) begin
      if (i != 0) @(negedge clk);
      if (latch) begin
        latch_cnt++;
        last_row = int'(row_pins);
        if (row_pins == 4'd7 && !dropped) begin
          en = 1'b0;
          dropped = 1'b1;
        end
      end
      if (frame) begin
        frame_cnt++;
        frame_at = i;
      end
      if (i >= FRAME && (!oe || clk_o || latch)) post_active++;
    end
    n_tests++;
    if (!dropped) begin
      $display("FAIL drop_row7 got no row-7 latch want one");
      n_fail++;
    end
    n_tests++;
    if (frame_cnt != 1 || frame_at != FRAME - 1) begin
      $display("FAIL drop_frame got %0d pulses at %0d want 1 at %0d",
               frame_cnt, frame_at, FRAME - 1);
      n_fail++;
    end
    n_tests++;
    if (latch_cnt != 64 || last_row != 15) begin
      $display("FAIL drop_complete got %0d latches last row %0d want 64, 15",
               latch_cnt, last_row);
      n_fail++;
    end
    n_tests++;
    if (post_active != 0 || oe !== 1'b1) begin
      $display("FAIL drop_idle got %0d active cycles oe=%b want 0, 1", post_active, oe);
      n_fail++;
    end
  endtask

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    test_reset();
    test_single_plane();
    test_addr_bits();
    test_bcm();
    test_frame();
    test_en_drop();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
